// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the in-place radix-2 DIF FFT sequencer.
//   LOG2N_DEF  default log2 of the transform length
//   N, HALF_N  transform length and butterflies per stage for the default size
//   state_t    sequencer state encoding
//   bitrev()   reverses the low 'bits' bits of an index; the transform leaves
//              its result in bit-reversed order, so consumers use this to
//              reorder bins.
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int LOG2N_DEF = 10;
    localparam int N         = 1 << LOG2N_DEF;
    localparam int HALF_N    = N / 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [11:0] bitrev(input logic [11:0] x, input int bits);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < 12; i++) begin
            if (i < bits) begin
                r[i] = x[bits - 1 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// -----------------------------------------------------------------------------
// fft_addr_gen
// Combinational butterfly address generator for one radix-2 DIF stage.
//   k_i   butterfly index within the stage (0..N/2-1)
//   s_i   stage index (0..LOG2N-1)
//   a_o   upper input address  a = g*2*span + j
//   b_o   lower input address  b = a + span
//   tw_o  twiddle ROM address  j << s (mod N/2)
// with span = N >> (s+1), j = k mod span, g = k div span.
// -----------------------------------------------------------------------------
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic [LOG2N-2:0]         k_i,
    input  logic [$clog2(LOG2N)-1:0] s_i,
    output logic [LOG2N-1:0]         a_o,
    output logic [LOG2N-1:0]         b_o,
    output logic [LOG2N-2:0]         tw_o
);

    localparam logic [LOG2N-1:0] HALF_VEC = LOG2N'(1 << (LOG2N - 1));

    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] mask;
    logic [LOG2N-1:0] j;
    logic [LOG2N-1:0] a_int;
    logic [LOG2N-1:0] tw_full;

    always_comb begin
        k_ext   = {1'b0, k_i};
        span    = HALF_VEC >> s_i;
        mask    = span - 1'b1;
        j       = k_ext & mask;
        // g*2*span is just k with its low (j) bits cleared, shifted up by one;
        // k's top bit is zero so the shift cannot overflow.
        a_int   = ((k_ext & ~mask) << 1) | j;
        tw_full = j << s_i;
        a_o     = a_int;
        b_o     = a_int | span;
        tw_o    = tw_full[LOG2N-2:0];
    end

endmodule

// File: rtl/fft_dif_ctrl.sv
// -----------------------------------------------------------------------------
// fft_dif_ctrl
// Sequencer for an in-place radix-2 DIF FFT feeding a butterfly unit with a
// one-cycle registered output. Runs LOG2N stages of N/2 butterflies per start.
//   clk, rst           clock, synchronous active-high reset
//   start              request one full pass (only looked at in IDLE)
//   busy               high from the first RUN cycle through the done pulse
//   done               one-cycle pulse with the final write-back
//   stage              current stage index, advances on RUN entry
//   rd_en, rd_addr_a/b read strobe and addresses for both RAM ports
//   tw_addr            twiddle ROM address issued with the reads
//   bf_enable          butterfly enable, aligned with RAM/ROM read data
//   wr_en, wr_addr_a/b write-back strobe and addresses, aligned with the
//                      registered butterfly outputs
// -----------------------------------------------------------------------------
module fft_dif_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(LOG2N)-1:0] stage,
    output logic                     rd_en,
    output logic [LOG2N-1:0]         rd_addr_a,
    output logic [LOG2N-1:0]         rd_addr_b,
    output logic [LOG2N-2:0]         tw_addr,
    output logic                     bf_enable,
    output logic                     wr_en,
    output logic [LOG2N-1:0]         wr_addr_a,
    output logic [LOG2N-1:0]         wr_addr_b
);

    localparam int               SW     = $clog2(LOG2N);
    localparam int               KW     = LOG2N - 1;
    localparam logic [KW-1:0]    K_LAST = '1;
    localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic              drain_q, drain_d;

    logic [LOG2N-1:0]  a_c, b_c;
    logic [KW-1:0]     tw_c;

    logic              vld_p1, vld_p2;
    logic [LOG2N-1:0]  wa_p1, wb_p1, wa_p2, wb_p2;

    fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
        .k_i  (k_q),
        .s_i  (stage_q),
        .a_o  (a_c),
        .b_o  (b_c),
        .tw_o (tw_c)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        drain_d = drain_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    k_d     = '0;
                    stage_d = '0;
                end
            end
            S_RUN: begin
                // k wrapping to zero is what ends the stage.
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                // Two cycles: the last butterfly needs one to pass the RAM/ROM
                // read and one to pass the butterfly register before write-back.
                drain_d = 1'b1;
                if (drain_q) begin
                    drain_d = 1'b0;
                    if (stage_q == S_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        stage_d = stage_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                stage_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            stage_q <= '0;
            drain_q <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            wa_p1   <= '0;
            wb_p1   <= '0;
            wa_p2   <= '0;
            wb_p2   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
            // p1: RAM/ROM read data valid, butterfly computing
            vld_p1  <= rd_en;
            wa_p1   <= rd_addr_a;
            wb_p1   <= rd_addr_b;
            // p2: butterfly output registered, write-back
            vld_p2  <= vld_p1;
            wa_p2   <= wa_p1;
            wb_p2   <= wb_p1;
        end
    end

    // Addresses are zeroed when idle so nothing but the strobe has to be
    // qualified downstream.
    assign rd_en     = (state_q == S_RUN);
    assign rd_addr_a = rd_en ? a_c  : '0;
    assign rd_addr_b = rd_en ? b_c  : '0;
    assign tw_addr   = rd_en ? tw_c : '0;
    assign bf_enable = vld_p1;
    assign wr_en     = vld_p2;
    assign wr_addr_a = wa_p2;
    assign wr_addr_b = wb_p2;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DRAIN) && drain_q && (stage_q == S_LAST);
    assign stage     = stage_q;

endmodule
